id_reg: RTL and testbench
=========================

# id_reg

Instruction-decode stage register for the 5-stage pipeline, directly downstream of the fetch stage. It consumes the fetched PC, instruction word and valid flag, and decodes the instruction fields. It reads the register file and registers the decoded bundle for the execute stage. It also detects load-use hazards against the instruction in execute and inserts a one-cycle bubble when required.

## Interface
- WORD_W, 32, instruction/data/PC width
- REG_AW, 5, register-file address width (32 GPRs, r0 hard-wired zero)

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- if_pc  input  32  PC of fetched instruction
- if_insn  input  32  fetched instruction (all-zero = NOP)
- if_en  input  1  fetched instruction valid
- stall  input  1  global hold from pipeline controller
- flush  input  1  kill instruction entering decode
- ex_load_en  input  1  instruction currently in execute is LW
- ex_dst_addr  input  5  destination register of instruction in execute
- rf_rd_addr0 / rf_rd_addr1  output  5  combinational rs = if_insn[25:21], rt = if_insn[20:16]
- rf_rd_data0 / rf_rd_data1  input  32  register-file read data, combinational
- load_hazard  output  1  combinational; high = fetch must hold PC/instruction this cycle
- id_pc, id_insn  output  32  registered PC/instruction
- id_en  output  1  registered valid
- id_op  output  6  registered opcode if_insn[31:26]
- id_ra_data, id_rb_data  output  32  registered rs/rt operand values
- id_imm  output  32  registered sign-extended if_insn[15:0]
- id_dst_addr  output  5  registered destination register
- id_gpr_we, id_mem_rd, id_mem_wr, id_illegal  output  1  registered control flags

## Operation
- Decode table (opcode → dst, uses_rt, flags):
  - 6'h00 R-type → rd, uses rt
  - 6'h08 ADDI → rt, no rt use
  - 6'h23 LW → rt, mem_rd=1
  - 6'h2B SW → no dst, uses rt, mem_wr=1
  - 6'h04 BEQ → no dst, uses rt
  - 6'h02 J → no dst, no rs/rt use
  - Any other opcode → id_illegal=1, no dst, gpr_we=0
- gpr_we = instruction has a dst AND dst≠0; a write to r0 is never enabled.
- A read of r0 yields 0 regardless of rf_rd_data.
- load_hazard = if_en & ex_load_en & ex_dst_addr≠0 & (ex_dst_addr==rs, for opcodes using rs, i.e. all except J | (uses_rt & ex_dst_addr==rt)). It is forced 0 while rst, stall or flush is high.
- Register update priority per clk edge:
  - rst: all outputs to 0; id_insn=0 (NOP).
  - stall: all registers hold, including when flush or hazard is also high. The controller re-asserts flush after stall drops.
  - flush: bubble.
  - load_hazard: bubble.
  - else: capture the decoded if_* bundle, with id_en=if_en.
- Bubble: id_en=0, id_insn=0, id_gpr_we=0, id_mem_rd=0, id_mem_wr=0, id_illegal=0. id_pc is still loaded with if_pc, for exception reporting.
- If if_en=0 on a normal capture, all control flags are forced 0 and id_en=0.

## Timing
- Decode latency: 1 cycle. Bundle on if_* at edge N appears on id_* after edge N.
- load_hazard is combinational, same cycle as the if_* inputs. Fetch holds, so the same instruction is presented again at N+1. With ex_load_en now 0, it is captured normally: net penalty exactly 1 cycle.
- Operand data is sampled at the capturing edge. The register file must be write-first or externally bypassed; no forwarding is performed here.
- rst is synchronous: asserted mid-stream, it clears on the next edge regardless of stall.

## Test plan
- Reset: rst=1 for 2 cycles with if_insn=32'h8C22_0004 and stall=1 → after the edge, id_en=0, id_insn=0, all flags 0, id_pc=0.
- Normal LW: if_pc=32'h100, if_insn=32'h8C22_FFFC, if_en=1, rf_rd_data0=32'h2000 → next cycle id_op=6'h23, id_dst_addr=2, id_gpr_we=1, id_mem_rd=1, id_imm=32'hFFFF_FFFC, id_ra_data=32'h2000.
- Load-use: ex_load_en=1, ex_dst_addr=2, if_insn=32'h0043_2020 (add r4,r2,r3) → load_hazard=1 the same cycle, then a bubble (id_en=0, id_pc=if_pc). With ex_load_en=0 the next cycle, the add is captured with id_dst_addr=4, id_gpr_we=1.
- No false hazard: ex_dst_addr=0 with ex_load_en=1 → load_hazard=0. ADDI with ex_dst_addr equal to rt (rt is its dst) → load_hazard=0.
- Stall vs flush: a valid SW is registered, then stall=1 and flush=1 together for 2 cycles → outputs unchanged. Then stall=0, flush=1 → bubble.
- Illegal/r0: opcode 6'h3F → id_illegal=1, id_gpr_we=0. ADDI with rt=0 → id_gpr_we=0. rs=0 with rf_rd_data0=32'hDEAD_BEEF → id_ra_data=0.

Source files
------------

// File: rtl/id_reg.sv
// id_reg: decode stage register. Decodes the fetched instruction, reads the
// register file, detects load-use hazards against execute and registers
// the decoded bundle (or a bubble) for the execute stage.
module id_reg #(
  parameter int WORD_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] if_pc,
  input  logic [WORD_W-1:0] if_insn,
  input  logic              if_en,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_load_en,
  input  logic [REG_AW-1:0] ex_dst_addr,
  output logic [REG_AW-1:0] rf_rd_addr0,
  output logic [REG_AW-1:0] rf_rd_addr1,
  input  logic [WORD_W-1:0] rf_rd_data0,
  input  logic [WORD_W-1:0] rf_rd_data1,
  output logic              load_hazard,
  output logic [WORD_W-1:0] id_pc,
  output logic [WORD_W-1:0] id_insn,
  output logic              id_en,
  output logic [5:0]        id_op,
  output logic [WORD_W-1:0] id_ra_data,
  output logic [WORD_W-1:0] id_rb_data,
  output logic [WORD_W-1:0] id_imm,
  output logic [REG_AW-1:0] id_dst_addr,
  output logic              id_gpr_we,
  output logic              id_mem_rd,
  output logic              id_mem_wr,
  output logic              id_illegal
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] insn;
    logic              en;
    logic [5:0]        op;
    logic [WORD_W-1:0] ra;
    logic [WORD_W-1:0] rb;
    logic [WORD_W-1:0] imm;
    logic [REG_AW-1:0] dst;
    logic              gpr_we;
    logic              mem_rd;
    logic              mem_wr;
    logic              illegal;
  } id_bundle_t;

  id_bundle_t bundle_q, bundle_d;

  logic [5:0]        op;
  logic [REG_AW-1:0] rs, rt, rd, dst;
  logic              has_dst, uses_rs, uses_rt, mem_rd, mem_wr, illegal;
  logic [WORD_W-1:0] ra_val, rb_val, imm_sx;

  assign op     = if_insn[31:26];
  assign rs     = if_insn[25:21];
  assign rt     = if_insn[20:16];
  assign rd     = if_insn[15:11];
  assign imm_sx = {{(WORD_W-16){if_insn[15]}}, if_insn[15:0]};
  // r0 reads as zero no matter what the register file returns
  assign ra_val = (rs == '0) ? '0 : rf_rd_data0;
  assign rb_val = (rt == '0) ? '0 : rf_rd_data1;

  assign rf_rd_addr0 = rs;
  assign rf_rd_addr1 = rt;

  // Opcode decode: destination, source usage and memory/illegal flags
  always_comb begin
    has_dst = 1'b0;
    dst     = '0;
    uses_rs = 1'b1;
    uses_rt = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_RTYPE: begin has_dst = 1'b1; dst = rd; uses_rt = 1'b1; end
      OP_ADDI:  begin has_dst = 1'b1; dst = rt; end
      OP_LW:    begin has_dst = 1'b1; dst = rt; mem_rd = 1'b1; end
      OP_SW:    begin uses_rt = 1'b1; mem_wr = 1'b1; end
      OP_BEQ:   begin uses_rt = 1'b1; end
      OP_J:     begin uses_rs = 1'b0; end
      default:  begin illegal = 1'b1; end
    endcase
  end

  // Load-use hazard against the LW in execute; suppressed while the stage
  // is reset, held or being flushed since nothing is captured then anyway
  always_comb begin
    load_hazard = if_en & ex_load_en & (ex_dst_addr != '0) & ~rst & ~stall & ~flush &
                  ((uses_rs & (ex_dst_addr == rs)) | (uses_rt & (ex_dst_addr == rt)));
  end

  // Next bundle: hold on stall, bubble on flush/hazard, else capture decode
  always_comb begin
    bundle_d = bundle_q;
    if (stall) begin
      bundle_d = bundle_q;
    end else if (flush || load_hazard) begin
      bundle_d    = '0;
      bundle_d.pc = if_pc;  // kept for exception reporting
    end else begin
      bundle_d.pc      = if_pc;
      bundle_d.insn    = if_insn;
      bundle_d.en      = if_en;
      bundle_d.op      = op;
      bundle_d.ra      = ra_val;
      bundle_d.rb      = rb_val;
      bundle_d.imm     = imm_sx;
      bundle_d.dst     = dst;
      bundle_d.gpr_we  = if_en & has_dst & (dst != '0);
      bundle_d.mem_rd  = if_en & mem_rd;
      bundle_d.mem_wr  = if_en & mem_wr;
      bundle_d.illegal = if_en & illegal;
    end
  end

  // Stage register; synchronous reset overrides stall
  always_ff @(posedge clk) begin
    if (rst) bundle_q <= '0;
    else     bundle_q <= bundle_d;
  end

  assign id_pc       = bundle_q.pc;
  assign id_insn     = bundle_q.insn;
  assign id_en       = bundle_q.en;
  assign id_op       = bundle_q.op;
  assign id_ra_data  = bundle_q.ra;
  assign id_rb_data  = bundle_q.rb;
  assign id_imm      = bundle_q.imm;
  assign id_dst_addr = bundle_q.dst;
  assign id_gpr_we   = bundle_q.gpr_we;
  assign id_mem_rd   = bundle_q.mem_rd;
  assign id_mem_wr   = bundle_q.mem_wr;
  assign id_illegal  = bundle_q.illegal;

endmodule

// File: tb/tb_id_reg.sv
// tb_id_reg: directed test-plan cases plus randomized traffic, checked
// against a behavioural model of the decode stage kept in this bench.
module tb_id_reg;
  logic        clk = 1'b0;
  logic        rst, if_en, stall, flush, ex_load_en;
  logic [31:0] if_pc, if_insn, rf_rd_data0, rf_rd_data1;
  logic [4:0]  ex_dst_addr, rf_rd_addr0, rf_rd_addr1, id_dst_addr;
  logic        load_hazard, id_en, id_gpr_we, id_mem_rd, id_mem_wr, id_illegal;
  logic [31:0] id_pc, id_insn, id_ra_data, id_rb_data, id_imm;
  logic [5:0]  id_op;

  always #5 clk = ~clk;

  id_reg dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_insn(if_insn), .if_en(if_en),
    .stall(stall), .flush(flush), .ex_load_en(ex_load_en), .ex_dst_addr(ex_dst_addr),
    .rf_rd_addr0(rf_rd_addr0), .rf_rd_addr1(rf_rd_addr1),
    .rf_rd_data0(rf_rd_data0), .rf_rd_data1(rf_rd_data1),
    .load_hazard(load_hazard), .id_pc(id_pc), .id_insn(id_insn), .id_en(id_en),
    .id_op(id_op), .id_ra_data(id_ra_data), .id_rb_data(id_rb_data), .id_imm(id_imm),
    .id_dst_addr(id_dst_addr), .id_gpr_we(id_gpr_we), .id_mem_rd(id_mem_rd),
    .id_mem_wr(id_mem_wr), .id_illegal(id_illegal)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // expected stage contents; m_full=0 after a bubble, whose data fields are don't-care
  logic [31:0] m_pc, m_insn, m_ra, m_rb, m_imm;
  logic [5:0]  m_op;
  logic [4:0]  m_dst;
  logic        m_en, m_we, m_mrd, m_mwr, m_ill, m_full;

  // Instruction semantics: which registers it reads/writes and its memory role
  task automatic decode(input logic [31:0] insn, output logic [4:0] dst, output logic we,
                        output logic mrd, output logic mwr, output logic ill,
                        output logic rd_rs, output logic rd_rt);
    logic [4:0] w;
    w = 5'd0; mrd = 0; mwr = 0; ill = 0; rd_rs = 1; rd_rt = 0;
    case (insn[31:26])
      6'h00: begin w = insn[15:11]; rd_rt = 1; end
      6'h08: w = insn[20:16];
      6'h23: begin w = insn[20:16]; mrd = 1; end
      6'h2B: begin mwr = 1; rd_rt = 1; end
      6'h04: rd_rt = 1;
      6'h02: rd_rs = 0;
      default: ill = 1;
    endcase
    dst = w;
    we  = (w != 0);
  endtask

  // One cycle: check combinational outputs, advance model, check registers
  task automatic step();
    logic [4:0] dst;
    logic we, mrd, mwr, ill, urs, urt, haz;
    @(negedge clk);
    decode(if_insn, dst, we, mrd, mwr, ill, urs, urt);
    haz = !rst && !stall && !flush && if_en && ex_load_en && ex_dst_addr != 0 &&
          ((urs && ex_dst_addr == if_insn[25:21]) || (urt && ex_dst_addr == if_insn[20:16]));
    chk("load_hazard", {31'd0, load_hazard}, {31'd0, haz});
    chk("rf_rd_addr0", {27'd0, rf_rd_addr0}, {27'd0, if_insn[25:21]});
    chk("rf_rd_addr1", {27'd0, rf_rd_addr1}, {27'd0, if_insn[20:16]});
    if (rst) begin
      {m_pc, m_insn, m_ra, m_rb, m_imm, m_op, m_dst} = '0;
      {m_en, m_we, m_mrd, m_mwr, m_ill} = '0;
      m_full = 1;
    end else if (stall) begin
      // everything held
    end else if (flush || haz) begin
      m_pc = if_pc; m_insn = 0; {m_en, m_we, m_mrd, m_mwr, m_ill} = '0; m_full = 0;
    end else begin
      m_pc = if_pc; m_insn = if_insn; m_en = if_en; m_op = if_insn[31:26];
      m_ra = (if_insn[25:21] == 0) ? 32'd0 : rf_rd_data0;
      m_rb = (if_insn[20:16] == 0) ? 32'd0 : rf_rd_data1;
      m_imm = 32'(signed'(if_insn[15:0]));
      m_dst = dst;
      m_we = we & if_en; m_mrd = mrd & if_en; m_mwr = mwr & if_en; m_ill = ill & if_en;
      m_full = 1;
    end
    @(posedge clk); #1;
    chk("id_pc", id_pc, m_pc);
    chk("id_insn", id_insn, m_insn);
    chk("id_en", {31'd0, id_en}, {31'd0, m_en});
    chk("id_flags", {28'd0, id_gpr_we, id_mem_rd, id_mem_wr, id_illegal},
        {28'd0, m_we, m_mrd, m_mwr, m_ill});
    if (m_full) begin
      chk("id_op", {26'd0, id_op}, {26'd0, m_op});
      chk("id_ra_data", id_ra_data, m_ra);
      chk("id_rb_data", id_rb_data, m_rb);
      chk("id_imm", id_imm, m_imm);
      chk("id_dst_addr", {27'd0, id_dst_addr}, {27'd0, m_dst});
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] insn, input logic en);
    if_pc = pc; if_insn = insn; if_en = en;
  endtask

  logic [5:0] ops [8] = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h3F, 6'h11};

  initial begin
    rst = 1; stall = 1; flush = 0; ex_load_en = 0; ex_dst_addr = 0;
    rf_rd_data0 = 32'h1111; rf_rd_data1 = 32'h2222;
    drive(32'h40, 32'h8C22_0004, 1);
    // reset, with stall also high
    step(); step();
    chk("rst_en_const", {31'd0, id_en}, 32'd0);
    rst = 0; stall = 0;

    // normal LW
    drive(32'h100, 32'h8C22_FFFC, 1); rf_rd_data0 = 32'h2000;
    step();
    chk("lw_imm_const", id_imm, 32'hFFFF_FFFC);

    // load-use on rs of add r4,r2,r3, then the retry
    ex_load_en = 1; ex_dst_addr = 5'd2; drive(32'h104, 32'h0043_2020, 1);
    step();
    chk("lu_bubble_en", {31'd0, id_en}, 32'd0);
    ex_load_en = 0;
    step();
    chk("lu_retry_dst", {27'd0, id_dst_addr}, 32'd4);

    // no false hazards
    ex_load_en = 1; ex_dst_addr = 5'd0; drive(32'h108, 32'h0000_2020, 1);
    step();
    ex_dst_addr = 5'd5; drive(32'h10C, {6'h08, 5'd1, 5'd5, 16'h0003}, 1);
    step();
    ex_load_en = 0;

    // SW registered, then stall+flush hold, then flush bubble
    drive(32'h110, {6'h2B, 5'd1, 5'd2, 16'h0010}, 1);
    step();
    stall = 1; flush = 1; drive(32'h114, 32'h0043_2020, 1);
    step(); step();
    chk("hold_mem_wr", {31'd0, id_mem_wr}, 32'd1);
    stall = 0;
    step();
    chk("flush_pc", id_pc, 32'h114);
    flush = 0;

    // illegal opcode, ADDI to r0, r0 source read
    drive(32'h118, 32'hFC22_0001, 1); step();
    drive(32'h11C, {6'h08, 5'd1, 5'd0, 16'h0005}, 1); step();
    rf_rd_data0 = 32'hDEAD_BEEF;
    drive(32'h120, {6'h08, 5'd0, 5'd3, 16'h0007}, 1); step();
    chk("r0_read_const", id_ra_data, 32'd0);
    // if_en=0 capture
    drive(32'h124, 32'h8C22_0004, 0); step();

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      rst         = ($urandom_range(0, 39) == 0);
      stall       = ($urandom_range(0, 7) == 0);
      flush       = ($urandom_range(0, 7) == 0);
      ex_load_en  = ($urandom_range(0, 2) == 0);
      ex_dst_addr = 5'($urandom_range(0, 3));
      rf_rd_data0 = $urandom;
      rf_rd_data1 = $urandom;
      drive($urandom,
            {ops[$urandom_range(0, 7)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 11'($urandom)},
            ($urandom_range(0, 5) != 0));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
